ram_responder: RTL and testbench

- Memory-side end of the CPU RAM bus: the CPU drives address, RW and write data; this block stores and returns 16-bit words.
- Single-port synchronous RAM with a post-reset clear sequencer, out-of-range address trapping and a ready indication.
- Sits between the CPU core and the top-level debug logic.
- Replaces the vendor RAM for simulation and small FPGA builds.

---
 rtl/ram_pkg.sv | 13 +
 rtl/ram_responder_if.sv | 25 ++
 rtl/ram_array.sv | 28 ++
 rtl/ram_responder.sv | 116 +++++++++++
 tb/tb_ram_responder.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared types and constants for the ram_responder memory slice.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ram_state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;
  localparam int   WORD_W   = 16;

endpackage

// File: rtl/ram_responder_if.sv
// CPU <-> RAM bus. The CPU (master) drives address, RW and write data every
// cycle; there is no valid/ready handshake on individual accesses: an access
// is taken on every rising clock edge once wire_ready is high, and read data
// appears on bus_RAM_DATA_OUT one cycle after the address edge.
interface ram_responder_if;
  import ram_pkg::*;

  logic [WORD_W-1:0] bus_RAM_ADDRESS;
  logic              wire_RW;
  logic [WORD_W-1:0] bus_RAM_DATA_IN;
  logic [WORD_W-1:0] bus_RAM_DATA_OUT;
  logic              wire_ready;
  logic              wire_addr_err;
  logic [WORD_W-1:0] bus_err_addr;

  modport master (
    output bus_RAM_ADDRESS, wire_RW, bus_RAM_DATA_IN,
    input  bus_RAM_DATA_OUT, wire_ready, wire_addr_err, bus_err_addr
  );

  modport slave (
    input  bus_RAM_ADDRESS, wire_RW, bus_RAM_DATA_IN,
    output bus_RAM_DATA_OUT, wire_ready, wire_addr_err, bus_err_addr
  );
endinterface

// File: rtl/ram_array.sv
// Pure storage: one synchronous write port and one synchronous read port.
// No reset; contents are defined by the clear sequencer in ram_responder.
module ram_array
  import ram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; a write on the previous edge is already visible.
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_responder.sv
// Memory-side end of the CPU RAM bus: post-reset clear sequencer, in-range
// read/write into ram_array, sticky out-of-range trap and ready flag.
// Optional macro RAM_WRITE_THROUGH_EN: echo write data on bus_RAM_DATA_OUT.
module ram_responder
  import ram_pkg::*;
#(
  parameter int                ADDR_W     = 10,
  parameter logic [WORD_W-1:0] INIT_VALUE = 16'h0000
) (
  input  logic            wire_clock,
  input  logic            wire_reset,
  ram_responder_if.slave  bus,
  output ram_state_t      dbg_state
);

  localparam logic [ADDR_W:0] CNT_LAST = {1'b0, {ADDR_W{1'b1}}};

  ram_state_t        state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ready_q;
  logic              err_q;
  logic [WORD_W-1:0] err_addr_q;
  logic              src_ram_q;
  logic [WORD_W-1:0] data_q;
  logic [WORD_W-1:0] rdata;
  logic [WORD_W-1:0] data_out;
  logic              in_range;
  logic              is_run;
  logic              cpu_we;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [WORD_W-1:0] arr_wdata;

  // The shift form also covers ADDR_W == WORD_W, where everything is in range.
  assign in_range  = ((bus.bus_RAM_ADDRESS >> ADDR_W) == '0);
  assign is_run    = (state_q == RUN);
  assign cpu_we    = is_run && (bus.wire_RW == RW_WRITE) && in_range;
  assign arr_we    = !wire_reset && ((state_q == CLEAR) || cpu_we);
  assign arr_waddr = (state_q == CLEAR) ? cnt_q[ADDR_W-1:0]
                                        : bus.bus_RAM_ADDRESS[ADDR_W-1:0];
  assign arr_wdata = (state_q == CLEAR) ? INIT_VALUE : bus.bus_RAM_DATA_IN;

  ram_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (wire_clock),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (bus.bus_RAM_ADDRESS[ADDR_W-1:0]),
    .rdata (rdata)
  );

  // Next state and clear counter: CLEAR walks every word once, RUN absorbs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  // State, counter and ready registers.
  always_ff @(posedge wire_clock) begin
    if (wire_reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == RUN);
    end
  end

  // Output source: in-range reads come straight from the array register,
  // everything else from data_q (zero, held value or echoed write data).
  always_ff @(posedge wire_clock) begin
    if (wire_reset || !is_run) begin
      src_ram_q <= 1'b0;
      data_q    <= '0;
    end else if (bus.wire_RW == RW_READ) begin
      src_ram_q <= in_range;
      data_q    <= '0;
    end else begin
      src_ram_q <= 1'b0;
`ifdef RAM_WRITE_THROUGH_EN
      data_q    <= in_range ? bus.bus_RAM_DATA_IN : '0;
`else
      data_q    <= data_out;
`endif
    end
  end

  // Sticky trap: only the first out-of-range address is kept.
  always_ff @(posedge wire_clock) begin
    if (wire_reset) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (is_run && !in_range && !err_q) begin
      err_q      <= 1'b1;
      err_addr_q <= bus.bus_RAM_ADDRESS;
    end
  end

  assign data_out             = src_ram_q ? rdata : data_q;
  assign bus.bus_RAM_DATA_OUT = data_out;
  assign bus.wire_ready       = ready_q;
  assign bus.wire_addr_err    = err_q;
  assign bus.bus_err_addr     = err_addr_q;
  assign dbg_state            = state_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder with ADDR_W=4, INIT_VALUE=16'hA5A5.
module tb_ram_responder;
  import ram_pkg::*;

  localparam logic [15:0] INIT = 16'hA5A5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_responder_if bus_if();
  ram_state_t      dbg_state;

  ram_responder #(.ADDR_W(4), .INIT_VALUE(INIT)) dut (
    .wire_clock (clk),
    .wire_reset (rst),
    .bus        (bus_if.slave),
    .dbg_state  (dbg_state)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Value seen on bus_RAM_DATA_OUT during a write cycle.
`ifdef RAM_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic [15:0] addr, input logic [15:0] din);
    bus_if.wire_RW         = rw;
    bus_if.bus_RAM_ADDRESS = addr;
    bus_if.bus_RAM_DATA_IN = din;
  endtask

  // Counts the clear sequence after reset release; ready must rise on cycle 16.
  // Optionally keeps attempting writes to addr 0 during CLEAR.
  task automatic run_clear(input string tag, input bit poke);
    for (int i = 1; i <= 16; i++) begin
      if (poke) drive(RW_WRITE, 16'h0000, 16'hDEAD);
      else      drive(RW_READ, 16'h0000, 16'h0000);
      cycle();
      n_cmp++;
      if (bus_if.wire_ready !== (i == 16)) begin
        n_mis++;
        $display("FAIL %s_ready cycle %0d: got %b want %b", tag, i, bus_if.wire_ready, (i == 16));
      end
      if (i == 8) begin
        n_cmp++;
        if (bus_if.bus_RAM_DATA_OUT !== 16'h0000) begin
          n_mis++;
          $display("FAIL %s_dout_clear: got %h want 0000", tag, bus_if.bus_RAM_DATA_OUT);
        end
      end
    end
    drive(RW_READ, 16'h0000, 16'h0000);
  endtask

  task automatic read_check(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    drive(RW_READ, addr, 16'h0000);
    cycle();
    n_cmp++;
    if (bus_if.bus_RAM_DATA_OUT !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, bus_if.bus_RAM_DATA_OUT, exp);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(RW_WRITE, 16'h0002, 16'h7777);
    cycle();
    cycle();
    n_cmp++;
    if (bus_if.bus_RAM_DATA_OUT !== 16'h0000) begin
      n_mis++; $display("FAIL reset_dout: got %h want 0000", bus_if.bus_RAM_DATA_OUT);
    end
    n_cmp++;
    if (bus_if.wire_ready !== 1'b0) begin
      n_mis++; $display("FAIL reset_ready: got %b want 0", bus_if.wire_ready);
    end
    n_cmp++;
    if (bus_if.wire_addr_err !== 1'b0 || bus_if.bus_err_addr !== 16'h0000) begin
      n_mis++; $display("FAIL reset_err: got %b/%h want 0/0000", bus_if.wire_addr_err, bus_if.bus_err_addr);
    end
    n_cmp++;
    if (dbg_state !== CLEAR) begin
      n_mis++; $display("FAIL reset_state: got %0d want %0d", dbg_state, CLEAR);
    end
    rst = 1'b0;
    run_clear("clear", 1'b0);
    n_cmp++;
    if (dbg_state !== RUN) begin
      n_mis++; $display("FAIL run_state: got %0d want %0d", dbg_state, RUN);
    end
    read_check("read_init_7", 16'h0007, INIT);
  endtask

  task automatic test_write_read();
    logic [15:0] exp_wr;
    exp_wr = WT ? 16'h1234 : INIT;
    drive(RW_WRITE, 16'h0003, 16'h1234);
    cycle();
    n_cmp++;
    if (bus_if.bus_RAM_DATA_OUT !== exp_wr) begin
      n_mis++; $display("FAIL write_cycle_dout: got %h want %h", bus_if.bus_RAM_DATA_OUT, exp_wr);
    end
    read_check("read_after_write_3", 16'h0003, 16'h1234);
  endtask

  task automatic test_out_of_range();
    logic [15:0] exp_wr;
    exp_wr = WT ? 16'h0000 : 16'h1234;
    drive(RW_WRITE, 16'h0013, 16'hBEEF);
    cycle();
    n_cmp++;
    if (bus_if.wire_addr_err !== 1'b1 || bus_if.bus_err_addr !== 16'h0013) begin
      n_mis++; $display("FAIL oor_trap: got %b/%h want 1/0013", bus_if.wire_addr_err, bus_if.bus_err_addr);
    end
    n_cmp++;
    if (bus_if.bus_RAM_DATA_OUT !== exp_wr) begin
      n_mis++; $display("FAIL oor_write_dout: got %h want %h", bus_if.bus_RAM_DATA_OUT, exp_wr);
    end
    read_check("oor_keeps_3", 16'h0003, 16'h1234);
    read_check("oor_read_13", 16'h0013, 16'h0000);
    read_check("oor_read_20", 16'h0020, 16'h0000);
    n_cmp++;
    if (bus_if.wire_addr_err !== 1'b1 || bus_if.bus_err_addr !== 16'h0013) begin
      n_mis++; $display("FAIL oor_sticky: got %b/%h want 1/0013", bus_if.wire_addr_err, bus_if.bus_err_addr);
    end
  endtask

  task automatic test_back_to_back();
    drive(RW_WRITE, 16'h0009, 16'h1111);
    cycle();
    drive(RW_WRITE, 16'h000A, 16'h2222);
    cycle();
    read_check("b2b_read_9", 16'h0009, 16'h1111);
    read_check("b2b_read_a", 16'h000A, 16'h2222);
    read_check("b2b_read_f", 16'h000F, INIT);
  endtask

  task automatic test_reset_mid_clear();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(RW_WRITE, 16'h0000, 16'hDEAD);
      cycle();
    end
    rst = 1'b1;
    cycle();
    n_cmp++;
    if (bus_if.wire_addr_err !== 1'b0 || bus_if.bus_err_addr !== 16'h0000) begin
      n_mis++; $display("FAIL mid_reset_err: got %b/%h want 0/0000", bus_if.wire_addr_err, bus_if.bus_err_addr);
    end
    rst = 1'b0;
    run_clear("mid_clear", 1'b1);
    read_check("mid_read_0", 16'h0000, INIT);
    read_check("mid_read_3", 16'h0003, INIT);
  endtask

  task automatic test_reset_with_write();
    drive(RW_WRITE, 16'h0005, 16'h5555);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run_clear("rw_clear", 1'b0);
    read_check("rw_read_5", 16'h0005, INIT);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    drive(RW_READ, 16'h0000, 16'h0000);
    test_reset();
    test_write_read();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_clear();
    test_reset_with_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
